// File: rtl/mem_bus_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory bus.
// Data accesses take priority; each access ends in a one-cycle completion pulse or a timeout error.
`ifndef HOLDPIP_BUS
`define HOLDPIP_BUS 2:0
`endif
`ifndef HOLD_NONE
`define HOLD_NONE 3'b000
`endif
`ifndef HOLD_WAIT
`define HOLD_WAIT 3'b001
`endif

module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TW      = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [AW-1:0]       if_addr_i,
    output logic [DW-1:0]       if_rdata_o,
    output logic                if_valid_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [AW-1:0]       d_addr_i,
    input  logic [DW-1:0]       d_wdata_i,
    input  logic [TW-1:0]       d_type_i,
    output logic [DW-1:0]       d_rdata_o,
    output logic                d_valid_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [AW-1:0]       bus_addr_o,
    output logic [DW-1:0]       bus_wdata_o,
    output logic [TW-1:0]       bus_type_o,
    input  logic                bus_ack_i,
    input  logic [DW-1:0]       bus_rdata_i,
    output logic [`HOLDPIP_BUS] hold_flag_o,
    output logic                err_o
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   cnt_reg;
    logic            we_reg;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   wdata_reg;
    logic [TW-1:0]   type_reg;

    logic            pulse_active;
    logic            grant_d;
    logic            grant_if;
    logic            busy;
    logic            timeout_hit;

    // No grant while a completion pulse is out: the requester still holds its level request then.
    assign pulse_active = if_valid_o | d_valid_o;
    assign grant_d      = d_req_i & ~pulse_active;
    assign grant_if     = ~d_req_i & if_req_i & ~pulse_active;
    assign busy         = (state_reg != IDLE);
    assign timeout_hit  = busy & ~bus_ack_i & (cnt_reg == TMO_VAL);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next = D_BUSY;
                end else if (grant_if) begin
                    state_next = IF_BUSY;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (bus_ack_i || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_req_o   = busy;
        bus_we_o    = we_reg;
        bus_addr_o  = addr_reg;
        bus_wdata_o = wdata_reg;
        bus_type_o  = type_reg;
        if ((d_req_i & ~d_valid_o) | (if_req_i & ~if_valid_o)) begin
            hold_flag_o = `HOLD_WAIT;
        end else begin
            hold_flag_o = `HOLD_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_reg    <= '0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            type_reg   <= '0;
            if_rdata_o <= '0;
            d_rdata_o  <= '0;
            if_valid_o <= 1'b0;
            d_valid_o  <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            if_valid_o <= 1'b0;
            d_valid_o  <= 1'b0;
            err_o      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (grant_d) begin
                        we_reg    <= d_we_i;
                        addr_reg  <= d_addr_i;
                        wdata_reg <= d_wdata_i;
                        type_reg  <= d_type_i;
                    end else if (grant_if) begin
                        we_reg    <= 1'b0;
                        addr_reg  <= if_addr_i;
                        wdata_reg <= '0;
                        type_reg  <= '0;
                    end
                end
                IF_BUSY, D_BUSY: begin
                    // Ack beats a coinciding timeout.
                    if (bus_ack_i) begin
                        if (state_reg == IF_BUSY) begin
                            if_valid_o <= 1'b1;
                            if_rdata_o <= bus_rdata_i;
                        end else begin
                            d_valid_o <= 1'b1;
                            d_rdata_o <= we_reg ? '0 : bus_rdata_i;
                        end
                    end else if (timeout_hit) begin
                        err_o <= 1'b1;
                        if (state_reg == IF_BUSY) begin
                            if_valid_o <= 1'b1;
                            if_rdata_o <= '0;
                        end else begin
                            d_valid_o <= 1'b1;
                            d_rdata_o <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: cnt_reg <= '0;
            endcase
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter AW, default 32, address width of all address ports.
REQ-002 Parameter DW, default 32, data width of all data ports.
REQ-003 Parameter TW, default 3, data-type code width; values are passed through unmodified.
REQ-004 Parameter TIMEOUT, default 15, maximum cycles spent waiting for bus_ack_i in a busy state.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-high: asserted when 1, sampled on rising edge of clk.
REQ-007 if_req_i  in  1  fetch read request, level, held until if_valid_o.
REQ-008 if_addr_i  in  AW  fetch address.
REQ-009 if_rdata_o  out  DW  fetch read data, meaningful only while if_valid_o.
REQ-010 if_valid_o  out  1  one-cycle fetch completion pulse.
REQ-011 d_req_i  in  1  data-access request (load or store) from the ex_memwb stage, level, held until d_valid_o.
REQ-012 d_we_i  in  1  1 = store, 0 = load.
REQ-013 d_addr_i  in  AW  data address.
REQ-014 d_wdata_i  in  DW  store data.
REQ-015 d_type_i  in  TW  data type code.
REQ-016 d_rdata_o  out  DW  load data, meaningful only while d_valid_o.
REQ-017 d_valid_o  out  1  one-cycle data completion pulse.
REQ-018 bus_req_o  out  1  shared memory bus request.
REQ-019 bus_we_o, bus_addr_o (AW), bus_wdata_o (DW), bus_type_o (TW)  out  shared bus command fields.
REQ-020 bus_ack_i  in  1  bus completion, one cycle.
REQ-021 bus_rdata_i  in  DW  bus read data, valid with bus_ack_i.
REQ-022 hold_flag_o  out  `holdpip_bus  pipeline hold request, `hold_wait or `hold_none.
REQ-023 err_o  out  1  one-cycle timeout error pulse.

Function
REQ-024 The block SHALL implement the registered states IDLE, IF_BUSY and D_BUSY.
REQ-025 In IDLE with d_req_i=1, the block SHALL latch d_we_i, d_addr_i, d_wdata_i and d_type_i, then enter D_BUSY; data access has fixed priority over fetch.
REQ-026 In IDLE with d_req_i=0 and if_req_i=1, the block SHALL latch if_addr_i with we=0 and type=0, then enter IF_BUSY.
REQ-027 In IF_BUSY/D_BUSY, bus_req_o SHALL be 1 and the bus command fields SHALL come from the latch, held stable regardless of input changes.
REQ-028 In IDLE, bus_req_o SHALL be 0; bus_ack_i SHALL be ignored.
REQ-029 Latency: grant one cycle after request in IDLE; bus_req_o asserted the cycle after that edge.
REQ-030 On bus_ack_i=1 in a busy state, the block SHALL register bus_rdata_i into the matching rdata output, pulse the matching valid output for exactly one cycle next cycle, and return to IDLE.
REQ-031 For stores, d_rdata_o SHALL be 0 at completion.
REQ-032 A wait counter SHALL clear on entry to a busy state and increment each busy cycle without ack.
REQ-033 When the counter equals TIMEOUT and bus_ack_i=0, the block SHALL pulse err_o and the matching valid output for one cycle with rdata 0, then return to IDLE.
REQ-034 If bus_ack_i and the timeout condition coincide, the ack SHALL win and err_o SHALL stay 0.
REQ-035 After any completion there SHALL be at least one IDLE cycle before the next grant.
REQ-036 hold_flag_o SHALL be `hold_wait when (d_req_i & ~d_valid_o) | (if_req_i & ~if_valid_o); otherwise `hold_none (combinational).
REQ-037 Request drop mid-access SHALL NOT abort the bus cycle; the completion pulse is still issued.

Reset
REQ-038 With rst_n=1 at a clock edge, state SHALL become IDLE and the counter 0; from the next cycle bus_req_o, if_valid_o, d_valid_o and err_o SHALL be 0, and all rdata outputs and latched fields SHALL be 0.
REQ-039 Reset mid-access SHALL abandon the bus cycle; a late bus_ack_i SHALL be ignored.

Verification
REQ-040 d_req_i=1, store, addr 0x100, wdata 0xDEADBEEF; ack 3 cycles after bus_req_o -> bus fields stable, one d_valid_o pulse, d_rdata_o=0, hold_wait until pulse.
REQ-041 if_req_i and d_req_i rise together -> data served first; fetch granted after the data pulse plus one IDLE cycle.
REQ-042 Fetch at 0x4, ack with bus_rdata_i=0x00000013 -> if_valid_o for 1 cycle, if_rdata_o=0x00000013.
REQ-043 No ack for TIMEOUT cycles -> err_o and d_valid_o pulse together, d_rdata_o=0, state IDLE.
REQ-044 Ack on the timeout cycle -> normal completion, err_o=0.
REQ-045 Reset during D_BUSY, then ack -> no valid pulse, bus_req_o=0, hold_flag_o follows request inputs.
